// File: rtl/rv_muldiv_unit.sv
// Multi-cycle RISC-V M-extension unit: multiplier with a configurable stage count and a
// restoring divider that resolves DIV_BITS quotient bits per cycle, with kill/flush support.
module rv_muldiv_unit #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned MUL_STAGES = 2,
    parameter int unsigned DIV_BITS   = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam int unsigned ITERS = XLEN / DIV_BITS;
    localparam int unsigned CW    = $clog2(XLEN + 1);
    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_STAGES - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(ITERS - 1);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] div_q;
    logic            quo_neg;
    logic            rem_neg;

    logic            accept;
    logic            is_mul;
    logic            div_signed;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] special_res;
    logic [XLEN:0]   sh;
    logic [XLEN-1:0] rem_n;
    logic [XLEN-1:0] quo_n;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;
    logic [XLEN-1:0] div_res;

    // Operands are widened to 2*XLEN so a single unsigned multiply covers all signedness modes.
    function automatic logic [XLEN-1:0] mul_res(input logic [2:0] f,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        logic [2*XLEN-1:0] ax;
        logic [2*XLEN-1:0] bx;
        logic [2*XLEN-1:0] p;
        ax = {{XLEN{(f[1:0] != 2'b11) & a[XLEN-1]}}, a};
        bx = {{XLEN{~f[1] & b[XLEN-1]}}, b};
        p  = ax * bx;
        return (f[1:0] == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    assign busy       = (state == StMul) || (state == StDiv);
    assign accept     = start && !kill && !busy;
    assign is_mul     = ~funct3[2];
    assign div_signed = ~funct3[0];
    assign div_zero   = (op_b == '0);
    assign div_ovf    = div_signed && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (&op_b);
    assign a_mag      = (div_signed && op_a[XLEN-1]) ? -op_a : op_a;
    assign b_mag      = (div_signed && op_b[XLEN-1]) ? -op_b : op_b;

    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = funct3[1] ? op_a : '1;
        end else begin
            special_res = funct3[1] ? '0 : op_a;
        end
    end

    // Restoring division: DIV_BITS shift/compare/subtract steps unrolled per cycle.
    always_comb begin
        sh    = '0;
        rem_n = rem_q;
        quo_n = quo_q;
        for (int i = 0; i < int'(DIV_BITS); i++) begin
            sh    = {rem_n, quo_n[XLEN-1]};
            quo_n = {quo_n[XLEN-2:0], 1'b0};
            if (sh >= {1'b0, div_q}) begin
                sh       = sh - {1'b0, div_q};
                quo_n[0] = 1'b1;
            end
            rem_n = sh[XLEN-1:0];
        end
        q_fix   = quo_neg ? -quo_n : quo_n;
        r_fix   = rem_neg ? -rem_n : rem_n;
        div_res = f3_q[1] ? r_fix : q_fix;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= StIdle;
            cnt     <= '0;
            f3_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rd_q    <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            quo_neg <= 1'b0;
            rem_neg <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            rd_out  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                StMul: begin
                    if (kill) begin
                        state <= StIdle;
                    end else if (cnt == MUL_LAST) begin
                        state  <= StIdle;
                        done   <= 1'b1;
                        result <= mul_res(f3_q, a_q, b_q);
                        rd_out <= rd_q;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                StDiv: begin
                    if (kill) begin
                        state <= StIdle;
                    end else begin
                        rem_q <= rem_n;
                        quo_q <= quo_n;
                        if (cnt == DIV_LAST) begin
                            // Sign fix-up is folded into the last step; StFix is the done cycle.
                            state  <= StFix;
                            done   <= 1'b1;
                            result <= div_res;
                            rd_out <= rd_q;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    state <= StIdle;
                    if (accept) begin
                        f3_q <= funct3;
                        rd_q <= rd_in;
                        if (is_mul) begin
                            a_q <= op_a;
                            b_q <= op_b;
                            cnt <= CW'(1);
                            if (MUL_STAGES == 1) begin
                                done   <= 1'b1;
                                result <= mul_res(funct3, op_a, op_b);
                                rd_out <= rd_in;
                            end else begin
                                state <= StMul;
                            end
                        end else if (div_zero || div_ovf) begin
                            state  <= StFix;
                            done   <= 1'b1;
                            result <= special_res;
                            rd_out <= rd_in;
                        end else begin
                            state   <= StDiv;
                            cnt     <= '0;
                            quo_q   <= a_mag;
                            rem_q   <= '0;
                            div_q   <= b_mag;
                            quo_neg <= div_signed && (op_a[XLEN-1] ^ op_b[XLEN-1]);
                            rem_neg <= div_signed && op_a[XLEN-1];
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Directed bench for rv_muldiv_unit: vector table for all eight functions, then hand-written
// kill / collision / back-to-back / async-reset sequences and a radix-16 divider instance.
module tb_rv_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_in;
    logic        kill;
    logic        busy1, done1, busy4, done4;
    logic [31:0] result1, result4;
    logic [4:0]  rd_out1, rd_out4;

    int checks = 0;
    int errors = 0;

    rv_muldiv_unit #(.XLEN(32), .MUL_STAGES(2), .DIV_BITS(1)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3), .op_a(op_a), .op_b(op_b),
        .rd_in(rd_in), .kill(kill), .busy(busy1), .done(done1), .result(result1),
        .rd_out(rd_out1)
    );

    rv_muldiv_unit #(.XLEN(32), .MUL_STAGES(2), .DIV_BITS(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3), .op_a(op_a), .op_b(op_b),
        .rd_in(rd_in), .kill(kill), .busy(busy4), .done(done4), .result(result4),
        .rd_out(rd_out4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        start  = 1'b1;
        funct3 = f;
        op_a   = a;
        op_b   = b;
        rd_in  = rd;
        @(posedge clk);
        #1;
        start = 1'b0;
        op_a  = 32'hDEAD_BEEF;
        op_b  = 32'h0BAD_F00D;
    endtask

    // Returns the cycle (counting the current one as 1) where done rises; -1 on timeout.
    task automatic wait_done(input bit sel4, output int lat, output int busy_bad);
        lat      = -1;
        busy_bad = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (sel4 ? done4 : done1) begin
                lat = c;
                break;
            end
            if (!(sel4 ? busy4 : busy1)) busy_bad++;
        end
    endtask

    task automatic count_done(input int n, output int seen);
        seen = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (done1) seen++;
        end
    endtask

    task automatic advance(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int lat, bb, seen;
        logic [31:0] last_res;
        logic [4:0]  last_rd;

        vecs[0]  = '{3'b000, 32'hFFFFFFFF, 32'h00000002, 5'd5,  32'hFFFFFFFE, 2};
        vecs[1]  = '{3'b001, 32'hFFFFFFFF, 32'h00000002, 5'd6,  32'hFFFFFFFF, 2};
        vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'h00000002, 5'd7,  32'h00000001, 2};
        vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'h00000002, 5'd8,  32'hFFFFFFFF, 2};
        vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'h00000002, 5'd9,  32'hFFFFFFFD, 33};
        vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'h00000002, 5'd10, 32'hFFFFFFFF, 33};
        vecs[6]  = '{3'b101, 32'h00001234, 32'h00000000, 5'd11, 32'hFFFFFFFF, 1};
        vecs[7]  = '{3'b111, 32'h00001234, 32'h00000000, 5'd12, 32'h00001234, 1};
        vecs[8]  = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000, 1};
        vecs[9]  = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h00000000, 1};
        vecs[10] = '{3'b101, 32'd100,      32'd7,        5'd15, 32'd14,       33};
        vecs[11] = '{3'b111, 32'd100,      32'd7,        5'd16, 32'd2,        33};
        vecs[12] = '{3'b000, 32'h12345678, 32'h00000010, 5'd17, 32'h23456780, 2};
        vecs[13] = '{3'b011, 32'h80000000, 32'h80000000, 5'd18, 32'h40000000, 2};
        vecs[14] = '{3'b100, 32'h00000007, 32'hFFFFFFFE, 5'd19, 32'hFFFFFFFD, 33};
        vecs[15] = '{3'b110, 32'h00000007, 32'hFFFFFFFE, 5'd20, 32'h00000001, 33};
        vecs[16] = '{3'b110, 32'hFFFFFFF9, 32'h00000000, 5'd21, 32'hFFFFFFF9, 1};
        vecs[17] = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 5'd22, 32'h80000000, 2};

        rst = 1'b1; start = 1'b0; kill = 1'b0; funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
        #12;
        check("reset busy", {31'd0, busy1}, 32'd0);
        check("reset done", {31'd0, done1}, 32'd0);
        check("reset result", result1, 32'd0);
        check("reset rd_out", {27'd0, rd_out1}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (vecs[i]) begin
            issue(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd);
            wait_done(1'b0, lat, bb);
            check($sformatf("vec%0d result", i), result1, vecs[i].res);
            check($sformatf("vec%0d rd_out", i), {27'd0, rd_out1}, {27'd0, vecs[i].rd});
            check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d busy gaps", i), bb, 0);
            @(negedge clk);
            check($sformatf("vec%0d done pulse", i), {31'd0, done1}, 32'd0);
            check($sformatf("vec%0d busy after", i), {31'd0, busy1}, 32'd0);
        end
        last_res = vecs[17].res;
        last_rd  = vecs[17].rd;

        // Kill at cycle 10 of DIVU 100/3
        issue(3'b101, 32'd100, 32'd3, 5'd9);
        advance(9);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        @(negedge clk);
        check("kill busy", {31'd0, busy1}, 32'd0);
        count_done(40, seen);
        check("kill no done", seen, 0);
        check("kill result held", result1, last_res);
        check("kill rd held", {27'd0, rd_out1}, {27'd0, last_rd});

        // start and kill in the same cycle
        kill = 1'b1;
        issue(3'b000, 32'd3, 32'd4, 5'd2);
        kill = 1'b0;
        @(negedge clk);
        check("start+kill busy", {31'd0, busy1}, 32'd0);
        count_done(10, seen);
        check("start+kill no done", seen, 0);

        // start at cycle 5 of a divide is ignored
        issue(3'b100, 32'hFFFFFFF9, 32'd2, 5'd3);
        advance(4);
        issue(3'b000, 32'd3, 32'd4, 5'd7);
        wait_done(1'b0, lat, bb);
        check("ignored start latency", lat, 28);
        check("ignored start result", result1, 32'hFFFFFFFD);
        check("ignored start rd", {27'd0, rd_out1}, 32'd3);
        count_done(5, seen);
        check("ignored start no extra done", seen, 0);

        // Back-to-back: DIVU issued in the MUL done cycle
        issue(3'b000, 32'hFFFFFFFF, 32'd2, 5'd5);
        wait_done(1'b0, lat, bb);
        check("b2b mul result", result1, 32'hFFFFFFFE);
        issue(3'b101, 32'd100, 32'd7, 5'd6);
        wait_done(1'b0, lat, bb);
        check("b2b div latency", lat, 33);
        check("b2b div result", result1, 32'd14);
        check("b2b div rd", {27'd0, rd_out1}, 32'd6);

        // Async reset mid-divide
        issue(3'b101, 32'd100, 32'd7, 5'd4);
        advance(4);
        #2;
        rst = 1'b1;
        #1;
        check("async rst busy", {31'd0, busy1}, 32'd0);
        check("async rst done", {31'd0, done1}, 32'd0);
        check("async rst result", result1, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        count_done(40, seen);
        check("async rst no done", seen, 0);

        // Radix-16 divider instance
        issue(3'b100, 32'hFFFFFFF9, 32'd2, 5'd11);
        wait_done(1'b1, lat, bb);
        check("radix16 div latency", lat, 9);
        check("radix16 div result", result4, 32'hFFFFFFFD);
        check("radix16 div rd", {27'd0, rd_out4}, 32'd11);
        issue(3'b110, 32'hFFFFFFF9, 32'd2, 5'd12);
        wait_done(1'b1, lat, bb);
        check("radix16 rem latency", lat, 9);
        check("radix16 rem result", result4, 32'hFFFFFFFF);
        check("radix16 busy gaps", bb, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv_muldiv_unit.md
Name: rv_muldiv_unit

Overview:
- Parametrised multi-cycle M-extension execution unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) that sits beside the ALU in the execute stage.
- The execute control logic issues one operation with a start pulse and holds the pipeline stall while busy is high.
- Completion is reported with a one-cycle done pulse, carrying the result and the destination-register tag for writeback.
- Generalises the single-cycle ALU path with configurable width, multiplier pipeline depth and divider radix, plus a flush (kill) input.

Parameters:
- XLEN, 32, operand/result width; must be even and >= 8.
- MUL_STAGES, 2, multiply latency in cycles from accepted start to done; legal 1..4.
- DIV_BITS, 1, quotient bits resolved per divide iteration; legal 1, 2 or 4; XLEN must be divisible by DIV_BITS.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  issue request, sampled on clk
- funct3  in  3  RISC-V M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  in  XLEN  rs1 value, sampled with start
- op_b  in  XLEN  rs2 value, sampled with start
- rd_in  in  5  destination register tag, sampled with start
- kill  in  1  flush; abandons any in-flight operation
- busy  out  1  operation in flight; drives stall
- done  out  1  one-cycle completion pulse
- result  out  XLEN  operation result; valid when done=1, held until next done
- rd_out  out  5  tag of the completing operation; valid with done

Behaviour:
- Reset (async, rst=1): state IDLE, busy=0, done=0, result=0, rd_out=0, all internal counters and accumulators cleared. Reset mid-operation discards the operation; no done follows.
- Acceptance:
  - start is accepted only when state is IDLE (busy=0) and kill=0.
  - start while busy is ignored; the in-flight operation is unaffected.
  - start and kill in the same cycle: kill wins, start is dropped.
- States: IDLE, MUL, DIV, FIX.
  - IDLE: accepted start with funct3[2]=0 goes to MUL; with funct3[2]=1 goes to DIV.
  - Exception: a divide with op_b=0 or signed overflow (DIV/REM with op_a=100..0, op_b=all ones) goes to FIX directly.
  - MUL: stage counter runs MUL_STAGES-1 cycles; the 2*XLEN product is formed from operands sign- or zero-extended per funct3.
    - MUL returns product[XLEN-1:0].
    - MULH, MULHSU and MULHU return product[2XLEN-1:XLEN].
  - DIV: restoring division on magnitudes, DIV_BITS quotient bits per cycle, XLEN/DIV_BITS cycles, then FIX.
  - FIX: applies signs (quotient negated if operand signs differ; remainder takes the sign of op_a), selects quotient or remainder, returns to IDLE.
- Latencies, from the cycle start is accepted (cycle 0) to the cycle done=1:
  - multiply: MUL_STAGES
  - normal divide: XLEN/DIV_BITS + 1
  - special-case divide: 1
- Special-case results:
  - divide by zero: DIV/DIVU quotient = all ones; REM/REMU = op_a.
  - signed overflow: DIV = op_a; REM = 0.
- busy is 1 from cycle 1 through the cycle before done. In the done cycle busy=0, so back-to-back start is accepted in the done cycle.
- done is high for exactly one cycle per completed operation. result and rd_out update only in the done cycle.
- kill while busy:
  - next state is IDLE; busy=0 the next cycle.
  - no done is issued for that operation; result and rd_out keep their previous values.
  - kill while IDLE has no effect.
- All arithmetic is modulo 2^XLEN on outputs. No internal overflow is exposed. Operands are registered at acceptance, so op_a and op_b may change afterwards.

Test Plan:
- XLEN=32, MUL_STAGES=2: start MUL op_a=0xFFFFFFFF, op_b=0x00000002, rd_in=5 -> done at cycle 2, result=0xFFFFFFFE, rd_out=5. Repeat with MULH -> 0xFFFFFFFF; MULHU -> 0x00000001; MULHSU -> 0xFFFFFFFF.
- DIV_BITS=1: DIV op_a=-7 (0xFFFFFFF9), op_b=2 -> busy for cycles 1..32, done at cycle 33, result=0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF.
- Divide by zero: DIVU op_a=0x1234, op_b=0 -> done at cycle 1, result=0xFFFFFFFF. REMU with the same operands -> 0x00001234.
- Overflow: DIV op_a=0x80000000, op_b=0xFFFFFFFF -> done at cycle 1, result=0x80000000. REM -> 0.
- Kill and start collisions:
  - DIVU 100/3 started, kill asserted at cycle 10 -> busy=0 at cycle 11, no done, result unchanged.
  - start with kill=1 in the same cycle -> not accepted.
  - start at cycle 5 of a divide -> ignored; the original op completes with the correct result.
- Back-to-back: MUL done cycle coincides with a new DIVU 100/7 start -> second op accepted, result=14.
- Async reset asserted mid-divide -> busy, done and result are 0 immediately, with no done after release.
- Repeat the divide test with DIV_BITS=4 -> done at cycle 9.
